// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: valid/ready pipeline stage with a one-entry skid buffer, flush, halt injection
// and saturating stall/bubble counters.
module id_ex_pipe_reg #(
    parameter int unsigned       DATA_W    = 160,
    parameter logic [DATA_W-1:0] HALT_DATA = DATA_W'(10),
    parameter int unsigned       CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    input  logic              halt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_halt,
    output logic              halted,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);
    typedef enum logic [2:0] {S_EMPTY, S_ONE, S_TWO, S_HALT, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d, skid_q, skid_d;
    logic              in_ready_q, in_ready_d, out_valid_q, out_valid_d;
    logic              out_halt_q, out_halt_d, halted_q, halted_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d, bubble_cnt_q, bubble_cnt_d;
    logic              accept, xfer;

    assign accept = in_valid & in_ready_q;
    assign xfer   = out_valid_q & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            S_EMPTY: begin
                if (accept) begin
                    main_d  = in_data;
                    state_d = S_ONE;
                end
            end
            S_ONE: begin
                if (accept && xfer) begin
                    main_d = in_data;
                end else if (accept) begin
                    skid_d  = in_data;
                    state_d = S_TWO;
                end else if (xfer) begin
                    main_d  = '0;
                    state_d = S_EMPTY;
                end
            end
            S_TWO: begin
                if (xfer) begin
                    main_d  = skid_q;
                    skid_d  = '0;
                    state_d = S_ONE;
                end
            end
            S_HALT: begin
                if (xfer) begin
                    main_d  = '0;
                    state_d = S_DONE;
                end
            end
            default: begin
                main_d  = '0;
                skid_d  = '0;
                state_d = S_DONE;
            end
        endcase
        // Halt outranks flush; both are ignored once the halt word has been issued.
        if (!(state_q inside {S_HALT, S_DONE})) begin
            if (halt) begin
                state_d = S_HALT;
                main_d  = HALT_DATA;
                skid_d  = '0;
            end else if (flush) begin
                state_d = S_EMPTY;
                main_d  = '0;
                skid_d  = '0;
            end
        end
        in_ready_d   = state_d inside {S_EMPTY, S_ONE};
        out_valid_d  = state_d inside {S_ONE, S_TWO, S_HALT};
        out_halt_d   = state_d == S_HALT;
        halted_d     = state_d inside {S_HALT, S_DONE};
        stall_cnt_d  = (out_valid_q && !out_ready && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
        bubble_cnt_d = (out_ready && !out_valid_q && !halted_q && !(&bubble_cnt_q)) ?
                       bubble_cnt_q + CNT_W'(1) : bubble_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_EMPTY;
            main_q       <= '0;
            skid_q       <= '0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            out_halt_q   <= 1'b0;
            halted_q     <= 1'b0;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_halt_q   <= out_halt_d;
            halted_q     <= halted_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_data   = main_q;
    assign out_halt   = out_halt_q;
    assign halted     = halted_q;
    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb_id_ex_pipe_reg: directed vector table plus hand sequences for saturation and async reset.
module tb_id_ex_pipe_reg;
    localparam int DW = 16;
    localparam int CW = 4;
    localparam logic [DW-1:0] HW = 16'hDEAD;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0, in_ready, flush = 1'b0, halt = 1'b0;
    logic          out_valid, out_ready = 1'b0, out_halt, halted;
    logic [DW-1:0] in_data = '0, out_data;
    logic [CW-1:0] stall_cnt, bubble_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    id_ex_pipe_reg #(.DATA_W(DW), .HALT_DATA(HW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .flush(flush), .halt(halt), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_halt(out_halt), .halted(halted),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    typedef struct packed {
        logic          iv;
        logic [DW-1:0] d;
        logic          ordy;
        logic          fl;
        logic          ht;
        logic          ov;
        logic [DW-1:0] od;
        logic          ir;
        logic          oh;
        logic          hd;
        logic [CW-1:0] st;
        logic [CW-1:0] bb;
    } vec_t;

    typedef logic [27:0] obs_t;

    function automatic obs_t pack(logic ov, logic [DW-1:0] od, logic ir, logic oh, logic hd,
                                  logic [CW-1:0] st, logic [CW-1:0] bb);
        return {ov, od, ir, oh, hd, st, bb};
    endfunction

    task automatic check(input string name, input obs_t exp);
        obs_t act;
        act = pack(out_valid, out_data, in_ready, out_halt, halted, stall_cnt, bubble_cnt);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got {ov,od,ir,oh,hd,st,bb}=%h expected %h", name, act, exp);
    endtask

    task automatic check_bubble(input string name, input logic [CW-1:0] exp);
        n_checks++;
        if (bubble_cnt === exp) n_pass++;
        else $display("FAIL %s: bubble_cnt got %0d expected %0d", name, bubble_cnt, exp);
    endtask

    task automatic drive(input logic iv, input logic [DW-1:0] d, input logic ordy,
                         input logic fl, input logic ht);
        in_valid = iv; in_data = d; out_ready = ordy; flush = fl; halt = ht;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs [30];

    initial begin
        //           iv  d       ordy fl ht   ov  od      ir oh hd st bb
        vecs[0]  = '{1, 16'd1,  1, 0, 0,   1, 16'd1,  1, 0, 0, 0, 1};
        for (int k = 1; k < 8; k++)
            vecs[k] = '{1, 16'(k + 1), 1, 0, 0, 1, 16'(k + 1), 1, 0, 0, 0, 1};
        vecs[8]  = '{0, 16'd0,  1, 0, 0,   0, 16'd0,  1, 0, 0, 0, 1};
        vecs[9]  = '{1, 16'd1,  0, 0, 0,   1, 16'd1,  1, 0, 0, 0, 1};
        vecs[10] = '{1, 16'd2,  0, 0, 0,   1, 16'd1,  0, 0, 0, 1, 1};
        vecs[11] = '{1, 16'd3,  0, 0, 0,   1, 16'd1,  0, 0, 0, 2, 1};
        vecs[12] = '{1, 16'd3,  0, 0, 0,   1, 16'd1,  0, 0, 0, 3, 1};
        vecs[13] = '{1, 16'd3,  1, 0, 0,   1, 16'd2,  1, 0, 0, 3, 1};
        vecs[14] = '{1, 16'd3,  1, 0, 0,   1, 16'd3,  1, 0, 0, 3, 1};
        vecs[15] = '{0, 16'd0,  1, 0, 0,   0, 16'd0,  1, 0, 0, 3, 1};
        vecs[16] = '{1, 16'd5,  0, 0, 0,   1, 16'd5,  1, 0, 0, 3, 1};
        vecs[17] = '{1, 16'd6,  0, 0, 0,   1, 16'd5,  0, 0, 0, 4, 1};
        vecs[18] = '{1, 16'd7,  0, 1, 0,   0, 16'd0,  1, 0, 0, 5, 1};
        vecs[19] = '{1, 16'd8,  1, 0, 0,   1, 16'd8,  1, 0, 0, 5, 2};
        vecs[20] = '{0, 16'd0,  1, 0, 0,   0, 16'd0,  1, 0, 0, 5, 2};
        vecs[21] = '{1, 16'd9,  1, 0, 0,   1, 16'd9,  1, 0, 0, 5, 3};
        vecs[22] = '{1, 16'd10, 1, 1, 0,   0, 16'd0,  1, 0, 0, 5, 3};
        vecs[23] = '{0, 16'd0,  1, 0, 0,   0, 16'd0,  1, 0, 0, 5, 4};
        vecs[24] = '{1, 16'd11, 0, 0, 0,   1, 16'd11, 1, 0, 0, 5, 4};
        vecs[25] = '{1, 16'd12, 0, 1, 1,   1, HW,     0, 1, 1, 6, 4};
        vecs[26] = '{1, 16'd13, 0, 0, 0,   1, HW,     0, 1, 1, 7, 4};
        vecs[27] = '{0, 16'd0,  1, 0, 0,   0, 16'd0,  0, 0, 1, 7, 4};
        vecs[28] = '{1, 16'd14, 1, 0, 1,   0, 16'd0,  0, 0, 1, 7, 4};
        vecs[29] = '{1, 16'd15, 1, 1, 0,   0, 16'd0,  0, 0, 1, 7, 4};

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("reset_state", pack(0, '0, 1, 0, 0, 0, 0));

        for (int i = 0; i < 30; i++) begin
            drive(vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].fl, vecs[i].ht);
            tick();
            check($sformatf("vec%0d", i),
                  pack(vecs[i].ov, vecs[i].od, vecs[i].ir, vecs[i].oh, vecs[i].hd, vecs[i].st, vecs[i].bb));
        end

        // Bubble counter saturation from a fresh reset.
        drive(0, '0, 0, 0, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("reset_after_halt", pack(0, '0, 1, 0, 0, 0, 0));
        out_ready = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 14) check_bubble("bubble_14", 4'd14);
            if (i == 15) check_bubble("bubble_sat", 4'd15);
            if (i == 20) check_bubble("bubble_hold", 4'd15);
        end

        // Asynchronous reset while holding two entries.
        drive(1, 16'd21, 0, 0, 0);
        tick();
        drive(1, 16'd22, 0, 0, 0);
        tick();
        check("fill_two", pack(1, 16'd21, 0, 0, 0, 1, 15));
        #3 rst_n = 1'b0;
        #1 check("async_reset", pack(0, '0, 1, 0, 0, 0, 0));
        drive(0, '0, 0, 0, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        check("post_reset_idle", pack(0, '0, 1, 0, 0, 0, 0));
        drive(1, 16'd23, 1, 0, 0);
        tick();
        check("post_reset_accept", pack(1, 16'd23, 1, 0, 0, 0, 1));
        drive(0, '0, 1, 0, 0);
        tick();
        check("post_reset_drain", pack(0, '0, 1, 0, 0, 0, 1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
